// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU load/store path, port 1 is the loader/debug master.
module dmem_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_we,
   input  logic [1:0][31:0] req_addr,
   input  logic [1:0][31:0] req_wdata,
   input  logic [1:0][3:0]  req_be,
   input  logic             p1_lock,
   output logic [1:0]       rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic             mem_en,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_be,
   input  logic [31:0]      mem_rdata,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic        owner_q, owner_d;
   logic        err_q, err_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        win;

   // Lock only overrides while port 1 already holds the last grant.
   always_comb begin
      win = 1'b0;
      unique case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = (p1_lock && last_grant_q) ? 1'b1 : ~last_grant_q;
         default: win = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lat_cnt_d    = lat_cnt_q;
      owner_d      = owner_q;
      err_d        = err_q;
      we_d         = we_q;
      rdata_d      = rdata_q;
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_rdata    = '0;
      rsp_err      = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_be       = '0;

      // Outputs are held at zero for the whole time reset is asserted.
      if (reset) begin
         unique case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  req_ready[win] = 1'b1;
                  owner_d        = win;
                  last_grant_d   = win;
                  we_d           = req_we[win];
                  if (req_addr[win] < ADDR_LIMIT) begin
                     mem_en    = 1'b1;
                     mem_we    = req_we[win];
                     mem_addr  = req_addr[win];
                     mem_wdata = req_wdata[win];
                     mem_be    = req_be[win];
                     lat_cnt_d = 3'd1;
                     state_d   = WAIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = RESP;
                  end
               end
            end
            WAIT: begin
               lat_cnt_d = lat_cnt_q + 3'd1;
               if (lat_cnt_q == 3'(MEM_LAT)) begin
                  rdata_d = mem_rdata;
                  state_d = RESP;
               end
            end
            RESP: begin
               rsp_valid[owner_q] = 1'b1;
               rsp_err            = err_q;
               rsp_rdata          = (we_q || err_q) ? '0 : rdata_q;
               err_d              = 1'b0;
               state_d            = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         lat_cnt_q    <= '0;
         owner_q      <= 1'b0;
         err_q        <= 1'b0;
         we_q         <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lat_cnt_q    <= lat_cnt_d;
         owner_q      <= owner_d;
         err_q        <= err_d;
         we_q         <= we_d;
         rdata_q      <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_dmem_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_we;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0][3:0]  req_be;
   logic             p1_lock;

   logic [1:0]  rdy1, rv1, rdy3, rv3;
   logic [31:0] rdata1, maddr1, mwd1, mrd1, rdata3, maddr3, mwd3, mrd3;
   logic        err1, men1, mwe1, busy1, err3, men3, mwe3, busy3;
   logic [3:0]  mbe1, mbe3;
   logic [31:0] p1a, p3a, p3b, p3c;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_LAT(1), .ADDR_LIMIT(32'h0000_1000)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .p1_lock(p1_lock), .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1),
      .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1),
      .mem_be(mbe1), .mem_rdata(mrd1), .busy(busy1));

   dmem_arbiter #(.MEM_LAT(3), .ADDR_LIMIT(32'h0000_1000)) u_dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .p1_lock(p1_lock), .rsp_valid(rv3), .rsp_rdata(rdata3), .rsp_err(err3),
      .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3),
      .mem_be(mbe3), .mem_rdata(mrd3), .busy(busy3));

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
   endfunction

   // Memory models: data is only valid exactly MEM_LAT cycles after mem_en.
   always @(posedge clk) begin
      p1a <= men1 ? mem_fn(maddr1) : 32'hBAD0_BAD0;
      p3a <= men3 ? mem_fn(maddr3) : 32'hBAD0_BAD0;
      p3b <= p3a;
      p3c <= p3b;
   end
   assign mrd1 = p1a;
   assign mrd3 = p3c;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; req_valid = '0; p1_lock = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (!busy1 && !busy3) break;
      end
      total_cnt++;
      if (busy1 || busy3) $display("FAIL wait_idle: busy1=%b busy3=%b expected 0 0", busy1, busy3);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      logic [113:0] o;
      reset = 1'b0; p1_lock = 1'b0; req_valid = 2'b11; req_we = '0;
      req_addr[0] = 32'h40; req_addr[1] = 32'h44; req_wdata = '0; req_be = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         o = {rdy1, rv1, rdata1, err1, men1, mwe1, maddr1, mwd1, mbe1, busy1};
         total_cnt++;
         if (o !== '0) $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, o);
         else pass_cnt++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++;
      if (rdy1 !== 2'b01) $display("FAIL reset_first_grant: ready=%b expected 01", rdy1);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_single_load();
      @(negedge clk);
      req_valid = 2'b01; req_we = '0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
      #1;
      total_cnt++;
      if ({rdy1, men1, mwe1, maddr1, mbe1} !== {2'b01, 1'b1, 1'b0, 32'h10, 4'hF})
         $display("FAIL load_grant: ready=%b en=%b we=%b addr=%h be=%h expected 01 1 0 00000010 f",
                  rdy1, men1, mwe1, maddr1, mbe1);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      #1;
      total_cnt++;
      if ({men1, busy1, rv1} !== {1'b0, 1'b1, 2'b00})
         $display("FAIL load_wait: en=%b busy=%b rsp_valid=%b expected 0 1 00", men1, busy1, rv1);
      else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++;
      if ({rv1, rdata1, err1} !== {2'b01, 32'hDEAD_BEEF, 1'b0})
         $display("FAIL load_rsp: valid=%b rdata=%h err=%b expected 01 deadbeef 0", rv1, rdata1, err1);
      else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++;
      if ({rv1, busy1} !== 3'b000) $display("FAIL load_done: valid=%b busy=%b expected 00 0", rv1, busy1);
      else pass_cnt++;
      wait_idle();
   endtask

   task automatic test_round_robin();
      int grants, rsps, cnt0, cnt1;
      logic [1:0] g, exp_g;
      logic bad;
      logic q_port[$];
      logic [31:0] q_addr[$];
      logic pp;
      logic [31:0] pa;
      do_reset();
      grants = 0; rsps = 0; cnt0 = 0; cnt1 = 0; bad = 1'b0;
      @(negedge clk);
      req_we = '0; req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_valid = 2'b11;
      for (int c = 0; c < 40 && (grants < 4 || rsps < 4); c++) begin
         #1;
         if (busy1 && rdy1 != 2'b00) bad = 1'b1;
         if (rv1 != 2'b00) begin
            total_cnt++;
            if (q_port.size() == 0) $display("FAIL rr_rsp_unexpected: valid=%b expected 00", rv1);
            else begin
               pp = q_port.pop_front(); pa = q_addr.pop_front();
               if ({rv1, rdata1, err1} !== {(pp ? 2'b10 : 2'b01), mem_fn(pa), 1'b0})
                  $display("FAIL rr_rsp%0d: valid=%b rdata=%h err=%b expected %b %h 0",
                           rsps, rv1, rdata1, err1, (pp ? 2'b10 : 2'b01), mem_fn(pa));
               else pass_cnt++;
            end
            rsps++;
         end
         g = req_valid & rdy1;
         if (g != 2'b00) begin
            exp_g = (grants % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++;
            if (g !== exp_g) $display("FAIL rr_grant%0d: got %b expected %b", grants, g, exp_g);
            else pass_cnt++;
            q_port.push_back(g[1]);
            q_addr.push_back(req_addr[g[1]]);
            grants++;
         end
         @(negedge clk);
         if (g[0]) begin cnt0++; req_addr[0] = 32'h100 + 32'(4 * cnt0); end
         if (g[1]) begin cnt1++; req_addr[1] = 32'h200 + 32'(4 * cnt1); end
         if (grants >= 4) req_valid = '0;
      end
      total_cnt++;
      if (grants != 4 || rsps != 4 || bad)
         $display("FAIL rr_progress: grants=%0d rsps=%0d busy_grant=%b expected 4 4 0", grants, rsps, bad);
      else pass_cnt++;
      wait_idle();
   endtask

   task automatic test_lock();
      int grants, rsps;
      logic [1:0] g, exp_g;
      logic q_port[$];
      logic pp;
      grants = 0; rsps = 0;
      @(negedge clk);
      req_we = '0; req_addr[0] = 32'h300; req_addr[1] = 32'h400; p1_lock = 1'b1; req_valid = 2'b11;
      for (int c = 0; c < 40 && (grants < 4 || rsps < 4); c++) begin
         #1;
         if (rv1 != 2'b00) begin
            total_cnt++;
            pp = (q_port.size() != 0) ? q_port.pop_front() : 1'b0;
            if (rv1 !== (pp ? 2'b10 : 2'b01))
               $display("FAIL lock_rsp%0d: valid=%b expected %b", rsps, rv1, (pp ? 2'b10 : 2'b01));
            else pass_cnt++;
            rsps++;
         end
         g = req_valid & rdy1;
         if (g != 2'b00) begin
            exp_g = (grants < 3) ? 2'b10 : 2'b01;
            total_cnt++;
            if (g !== exp_g) $display("FAIL lock_grant%0d: got %b expected %b", grants, g, exp_g);
            else pass_cnt++;
            q_port.push_back(g[1]);
            grants++;
         end
         @(negedge clk);
         if (grants >= 3) p1_lock = 1'b0;
         if (grants >= 4) req_valid = '0;
      end
      total_cnt++;
      if (grants != 4 || rsps != 4)
         $display("FAIL lock_progress: grants=%0d rsps=%0d expected 4 4", grants, rsps);
      else pass_cnt++;
      wait_idle();
   endtask

   task automatic test_out_of_range();
      // Port 1 store exactly at the limit.
      @(negedge clk);
      req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 32'h0000_1000; req_wdata[1] = 32'h1234_5678;
      #1;
      total_cnt++;
      if ({rdy1, men1} !== {2'b10, 1'b0}) $display("FAIL oor_grant: ready=%b en=%b expected 10 0", rdy1, men1);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      #1;
      total_cnt++;
      if ({rv1, err1, rdata1, men1} !== {2'b10, 1'b1, 32'h0, 1'b0})
         $display("FAIL oor_rsp: valid=%b err=%b rdata=%h en=%b expected 10 1 00000000 0", rv1, err1, rdata1, men1);
      else pass_cnt++;
      wait_idle();
      // Top of the address space must not wrap into range.
      @(negedge clk);
      req_valid = 2'b01; req_we = '0; req_addr[0] = 32'hFFFF_FFFF;
      #1;
      total_cnt++;
      if ({rdy1, men1} !== {2'b01, 1'b0}) $display("FAIL oor_max_grant: ready=%b en=%b expected 01 0", rdy1, men1);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      #1;
      total_cnt++;
      if ({rv1, err1} !== {2'b01, 1'b1}) $display("FAIL oor_max_rsp: valid=%b err=%b expected 01 1", rv1, err1);
      else pass_cnt++;
      wait_idle();
      // Last legal word as a store: passes through, response data is zero.
      @(negedge clk);
      req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 32'h0000_0FFC; req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'h6;
      #1;
      total_cnt++;
      if ({men1, mwe1, maddr1, mwd1, mbe1} !== {1'b1, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'h6})
         $display("FAIL store_edge_mem: en=%b we=%b addr=%h wdata=%h be=%h expected 1 1 00000ffc cafef00d 6",
                  men1, mwe1, maddr1, mwd1, mbe1);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      total_cnt++;
      if ({rv1, err1, rdata1} !== {2'b01, 1'b0, 32'h0})
         $display("FAIL store_edge_rsp: valid=%b err=%b rdata=%h expected 01 0 00000000", rv1, err1, rdata1);
      else pass_cnt++;
      req_we = '0;
      wait_idle();
   endtask

   task automatic test_reset_midop();
      logic [113:0] o;
      logic saw;
      do_reset();
      @(negedge clk);
      req_valid = 2'b01; req_we = '0; req_addr[0] = 32'h20;
      #1;
      total_cnt++;
      if ({rdy3, men3} !== {2'b01, 1'b1}) $display("FAIL midop_grant: ready=%b en=%b expected 01 1", rdy3, men3);
      else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      o = {rdy3, rv3, rdata3, err3, men3, mwe3, maddr3, mwd3, mbe3, busy3};
      total_cnt++;
      if (o !== '0) $display("FAIL midop_reset_outputs: got %h expected 0", o);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (rv3 != 2'b00) saw = 1'b1;
      end
      total_cnt++;
      if ({saw, busy3} !== 2'b00) $display("FAIL midop_no_rsp: saw_rsp=%b busy=%b expected 0 0", saw, busy3);
      else pass_cnt++;
      @(negedge clk);
      req_valid = 2'b10; req_addr[1] = 32'h30;
      #1;
      total_cnt++;
      if (rdy3 !== 2'b10) $display("FAIL midop_regrant: ready=%b expected 10", rdy3);
      else pass_cnt++;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = '0;
         #1;
         total_cnt++;
         if (k < 4) begin
            if (rv3 !== 2'b00) $display("FAIL midop_lat%0d: valid=%b expected 00", k, rv3);
            else pass_cnt++;
         end else begin
            if ({rv3, rdata3, err3} !== {2'b10, mem_fn(32'h30), 1'b0})
               $display("FAIL midop_rsp: valid=%b rdata=%h err=%b expected 10 %h 0", rv3, rdata3, err3, mem_fn(32'h30));
            else pass_cnt++;
         end
      end
      wait_idle();
   endtask

   initial begin
      reset = 1'b0; req_valid = '0; req_we = '0; req_addr = '0;
      req_wdata = '0; req_be = '0; p1_lock = 1'b0;
      test_reset();
      test_single_load();
      test_round_robin();
      test_lock();
      test_out_of_range();
      test_reset_midop();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port data memory (dmem) between two requesters.
- Port 0 is the CPU load/store path. Port 1 is the program loader / debug master.
- Accepts at most one transaction at a time, drives the dmem port, waits the fixed memory read latency, then returns a response to the owning requester.
- Sits between the CPU datapath, the debug/loader logic and the dmem instance.

Parameters:
- MEM_LAT, 1, dmem read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
- ADDR_LIMIT, 32'h0000_1000, first illegal byte address; any request with addr >= ADDR_LIMIT is rejected with an error response.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- req_we  in  2  per-port write enable (1 = store, 0 = load).
- req_addr  in  2x32  per-port byte address.
- req_wdata  in  2x32  per-port store data.
- req_be  in  2x4  per-port byte enables.
- p1_lock  in  1  port 1 atomic-sequence lock; while 1 after a port-1 grant, port 1 keeps priority.
- rsp_valid  out  2  one-cycle response pulse to the owning port.
- rsp_rdata  out  32  load data, shared by both ports; qualified by rsp_valid.
- rsp_err  out  1  out-of-range error flag, qualified by rsp_valid.
- mem_en  out  1  dmem access strobe, asserted for one cycle per access.
- mem_we  out  1  dmem write enable.
- mem_addr  out  32  dmem byte address.
- mem_wdata  out  32  dmem write data.
- mem_be  out  4  dmem byte enables.
- mem_rdata  in  32  dmem read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high while a transaction is in flight (states WAIT and RESP).

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1, lat_cnt=0, owner=0, err_q=0.
  - All outputs 0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, busy=0.
  - Reset mid-transaction drops the in-flight access; no rsp_valid is ever issued for it.
- IDLE:
  - req_ready is combinational. Exactly one bit is asserted, and only if some req_valid is 1.
  - Winner selection:
    - Only one port valid: that port wins.
    - Both ports valid: the port != last_grant wins.
    - Lock override: if p1_lock=1 and last_grant=1, port 1 wins whenever req_valid[1]=1.
  - On grant: owner<=winner and last_grant<=winner.
    - In range (addr < ADDR_LIMIT): mem_en=1 in the same cycle, with mem_we/addr/wdata/be passed through from the winner; lat_cnt<=1; next state WAIT.
    - Out of range: mem_en stays 0; err_q<=1; next state RESP directly.
- WAIT:
  - req_ready=0; mem_en=0.
  - lat_cnt increments each cycle.
  - When lat_cnt==MEM_LAT: register mem_rdata into rsp_rdata; next state RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - rsp_rdata = captured data for loads; 0 for stores and for errors.
  - rsp_err = err_q.
  - err_q<=0; next state IDLE.
  - req_ready stays 0 this cycle, so back-to-back acceptance is impossible.
- Latency and throughput:
  - In-range access: grant cycle to rsp_valid = MEM_LAT+1 cycles.
  - Error response: arrives 1 cycle after the grant.
  - Sustained throughput: one access per MEM_LAT+2 cycles.
- Requester obligations:
  - Requests are not withdrawn: once req_valid[i]=1, it holds with stable fields until req_ready[i]=1.
  - The arbiter captures nothing beyond the grant cycle except owner/we. The dmem is required to latch its inputs on the mem_en edge.
- Simultaneous events: a req_valid that rises while state != IDLE is ignored until IDLE. The round-robin decision is based only on the req_valid values present in the IDLE cycle.
- Lock starvation: p1_lock=1 held indefinitely starves port 0, by design.
- busy = (state != IDLE).
- Address compare is unsigned 32-bit. Address 0xFFFF_FFFF is out of range, with no wrap-around.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=2'b11, then release -> all outputs 0 during reset. First grant goes to port 0 (last_grant resets to 1).
- Single load, MEM_LAT=1: port0 load at addr 0x10, mem model returns 0xDEADBEEF -> mem_en one cycle, mem_addr=0x10. rsp_valid=2'b01 exactly 2 cycles after grant, with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Round-robin: both ports valid continuously for 4 transactions -> grant order 0,1,0,1. Each response goes to the matching port; no grant occurs in WAIT or RESP.
- Lock: p1_lock=1 with both ports valid after a port-1 grant -> port 1 granted 3 times consecutively. After p1_lock drops, the next grant goes to port 0.
- Out of range: port1 store to 0x0000_1000 -> mem_en never asserted. rsp_valid=2'b10 with rsp_err=1 and rsp_rdata=0, one cycle after grant.
- Reset mid-op: with MEM_LAT=3, assert reset in the WAIT cycle where lat_cnt=2 -> no rsp_valid is issued. After release, state=IDLE and a new request is granted normally.
